md5_block_builder: RTL and testbench
====================================

Name: md5_block_builder

Overview:
Producer end of the hash search pipeline. It absorbs a secret key as a byte stream, then emits one MD5-padded 512-bit message block per candidate. Each block is the key followed by the ASCII decimal nonce, counting 1, 2, 3, …. Blocks feed the MD5 core, whose digests go to the leading-zero filter. The filter's hit pulse returns on `stop`.

Parameters:
- MAX_KEY_BYTES, 16, maximum accepted key length in bytes.
- COUNTER_DIGITS, 8, maximum decimal digits of the nonce. Elaboration error if MAX_KEY_BYTES+COUNTER_DIGITS > 55.
- BLOCK_WIDTH, 512, message block width; fixed by MD5.
- NONCE_WIDTH, 32, width of the binary nonce sideband; must hold 10^COUNTER_DIGITS-1.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- key_valid  in  1  key byte strobe
- key_ready  out  1  high only in LOAD
- key_data  in  8  key byte, ASCII
- key_last  in  1  marks final key byte
- key_error  out  1  sticky; key exceeded MAX_KEY_BYTES
- block_valid  out  1  block available
- block_ready  in  1  MD5 core accepts block
- block_data  out  BLOCK_WIDTH  padded block; byte i at bits [8i+7:8i]
- block_nonce  out  NONCE_WIDTH  binary nonce of current block
- stop  in  1  filter hit; halt generation
- overflow  out  1  sticky; nonce space exhausted
- halted  out  1  state is HALT

Behaviour:
- Decided: reset reset, synchronous, active-high; clock clk.
- Reset values: state LOAD, key length 0, nonce 1 (BCD), key_ready 1, block_valid 0, block_nonce 1, key_error 0, overflow 0, halted 0. block_data is don't-care.
- A reset in any state, including mid-key or mid-run, returns to LOAD and discards the key.
- States are LOAD, RUN and HALT.
- LOAD, byte acceptance:
  - A byte is accepted on key_valid && key_ready and stored at index key_len.
  - Once key_len = MAX_KEY_BYTES, further bytes are dropped and key_error is set; key_ready stays high.
- LOAD, exit: accepting key_last moves to RUN. The block for nonce 1 is valid the next cycle.
- Block format, with L = key_len + ndigits:
  - bytes 0..key_len-1: key
  - next ndigits bytes: ASCII digits, most significant first, no leading zeros
  - byte L: 8'h80
  - bytes L+1..55: 8'h00
  - bytes 56..63: 64-bit little-endian bit length 8*L
- The block register is combinationally formatted from key and BCD state, then registered. block_data and block_nonce are registered and held stable while block_valid && !block_ready.
- RUN, handshake: on block_valid && block_ready the nonce increments (BCD and binary) and the next block is loaded that same edge. block_valid stays high, giving one block per cycle under continuous ready.
- BCD carry:
  - a digit at 9 wraps to 0 and carries;
  - a carry out of the top active digit sets ndigits+1 and that digit to 1 (e.g. 99 → 100).
- Overflow: a handshake of nonce 10^COUNTER_DIGITS-1 sets overflow and enters HALT; block_valid drops next cycle.
- stop:
  - stop in RUN enters HALT and block_valid drops next cycle.
  - If stop and a handshake coincide, the handshake completes and the nonce increments, but no further block is offered.
  - stop in LOAD or HALT is ignored.
- HALT: block_valid is 0, key_ready is 0 and halted is 1. Only reset leaves HALT.
- Empty key (key_last on first byte): a single key byte is still taken; a zero-length key is not supported.

Decomposition:
- Package md5_pkg holds:
  - typedef block_t as logic [511:0];
  - typedef byte_t;
  - MD5_PAD_BYTE = 8'h80;
  - ASCII_ZERO = 8'h30;
  - LENGTH_FIELD_OFFSET = 56;
  - the state enum.
- Sub-module bcd_counter (COUNTER_DIGITS) has inputs clear and incr. Its outputs are the digit vector, ndigits, a binary mirror, and at_max.

Test Plan:
- Key "abcdef" → first block bytes are "abcdef1", byte7=8'h80, byte56=8'h38, bytes 57-63 = 0, block_nonce=1, valid one cycle after key_last.
- Continuous ready: 9 → 10 transition → nonce 10 block "abcdef10", byte8=8'h80, byte56=8'h40. Nonce 609043 gives length 12 and byte56=8'h60.
- Random block_ready backpressure → block_data and block_nonce stable while stalled, no nonce skipped or repeated across 1000 handshakes.
- stop asserted coincident with handshake of nonce 5 → nonce 5 consumed, block_valid=0 next cycle, halted=1. key_valid is then ignored.
- COUNTER_DIGITS=2 → handshake of 99 sets overflow=1 and halted=1, no block 100. A 17-byte key with MAX_KEY_BYTES=16 sets key_error and the block uses the first 16 bytes.
- Reset asserted mid-RUN with ready high → next cycle block_valid=0, key_ready=1. Reloading key "xy" gives first block "xy1", nonce 1.

Source files
------------

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared types and constants for the MD5 block builder
package md5_pkg;

  typedef logic [511:0] block_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t MD5_PAD_BYTE        = 8'h80;
  localparam byte_t ASCII_ZERO          = 8'h30;
  localparam int    LENGTH_FIELD_OFFSET = 56;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - decimal nonce counter with active digit count and binary mirror
module bcd_counter #(
  parameter  int COUNTER_DIGITS = 8,
  parameter  int NONCE_WIDTH    = 32,
  localparam int ND_W           = $clog2(COUNTER_DIGITS + 1)
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        incr,
  output logic [4*COUNTER_DIGITS-1:0] digits,
  output logic [ND_W-1:0]             ndigits,
  output logic [NONCE_WIDTH-1:0]      binary,
  output logic                        at_max
);

  logic [4*COUNTER_DIGITS-1:0] digits_d;
  logic [ND_W-1:0]             ndigits_d;
  logic                        carry;
  logic                        all_nine;

  // Digits above the active count are always zero, so a carry into one opens a new top digit.
  always_comb begin
    digits_d  = digits;
    ndigits_d = ndigits;
    carry     = 1'b1;
    all_nine  = (ndigits == ND_W'(COUNTER_DIGITS));
    for (int i = 0; i < COUNTER_DIGITS; i++) begin
      if (digits[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (carry) begin
        if (ND_W'(i) >= ndigits) begin
          digits_d[4*i +: 4] = 4'd1;
          ndigits_d          = ND_W'(i + 1);
          carry              = 1'b0;
        end else if (digits[4*i +: 4] == 4'd9) begin
          digits_d[4*i +: 4] = 4'd0;
        end else begin
          digits_d[4*i +: 4] = digits[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  assign at_max = all_nine;

  always_ff @(posedge clk) begin
    if (clear) begin
      digits  <= (4*COUNTER_DIGITS)'(1);
      ndigits <= ND_W'(1);
      binary  <= NONCE_WIDTH'(1);
    end else if (incr) begin
      digits  <= digits_d;
      ndigits <= ndigits_d;
      binary  <= binary + NONCE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/md5_block_builder.sv
// rtl/md5_block_builder.sv - loads a key, then emits one MD5-padded block per decimal nonce
module md5_block_builder
  import md5_pkg::*;
#(
  parameter int MAX_KEY_BYTES  = 16,
  parameter int COUNTER_DIGITS = 8,
  parameter int BLOCK_WIDTH    = 512,
  parameter int NONCE_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [7:0]             key_data,
  input  logic                   key_last,
  output logic                   key_error,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic [BLOCK_WIDTH-1:0] block_data,
  output logic [NONCE_WIDTH-1:0] block_nonce,
  input  logic                   stop,
  output logic                   overflow,
  output logic                   halted
);

  localparam int KL_W = $clog2(MAX_KEY_BYTES + 1);
  localparam int ND_W = $clog2(COUNTER_DIGITS + 1);

  if (MAX_KEY_BYTES + COUNTER_DIGITS > 55) begin : g_size_check
    $error("md5_block_builder: key plus nonce digits cannot fit in one block");
  end
  if (BLOCK_WIDTH != 512) begin : g_width_check
    $error("md5_block_builder: BLOCK_WIDTH must be 512");
  end

  state_t                      state_q, state_d;
  byte_t                       key_mem [MAX_KEY_BYTES];
  byte_t                       key_view [MAX_KEY_BYTES];
  logic [KL_W-1:0]             key_len, len_view;
  logic                        key_take, key_wr, key_done, handshake, load_block;
  logic [4*COUNTER_DIGITS-1:0] cnt_digits;
  logic [ND_W-1:0]             cnt_ndigits;
  logic [NONCE_WIDTH-1:0]      cnt_binary;
  logic                        cnt_at_max;
  byte_t                       fmt_bytes [64];
  block_t                      fmt_block, block_q;
  logic [63:0]                 bit_len;
  logic                        block_valid_q, block_at_max_q, key_error_q, overflow_q;
  logic [NONCE_WIDTH-1:0]      block_nonce_q;

  assign key_take   = key_valid && key_ready;
  assign key_wr     = key_take && (key_len < KL_W'(MAX_KEY_BYTES));
  assign key_done   = key_take && key_last;
  assign handshake  = (state_q == ST_RUN) && block_valid_q && block_ready;
  assign load_block = key_done || (handshake && !block_at_max_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (key_done) state_d = ST_RUN;
      ST_RUN:  if (stop || (handshake && block_at_max_q)) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    key_ready = (state_q == ST_LOAD);
    halted    = (state_q == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_len     <= '0;
      key_error_q <= 1'b0;
    end else if (key_take) begin
      if (key_wr) key_len     <= key_len + KL_W'(1);
      else        key_error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_KEY_BYTES; i++)
      if (key_wr && (key_len == KL_W'(i))) key_mem[i] <= key_data;
  end

  // The first block is formatted on the key_last edge, so fold the in-flight byte in.
  always_comb begin
    for (int i = 0; i < MAX_KEY_BYTES; i++)
      key_view[i] = (key_wr && (key_len == KL_W'(i))) ? key_data : key_mem[i];
    len_view = key_wr ? key_len + KL_W'(1) : key_len;
  end

  always_comb begin
    for (int p = 0; p < 64; p++) fmt_bytes[p] = 8'h00;
    for (int i = 0; i < MAX_KEY_BYTES; i++)
      if (KL_W'(i) < len_view) fmt_bytes[i] = key_view[i];
    for (int j = 0; j < COUNTER_DIGITS; j++)
      if (ND_W'(j) < cnt_ndigits)
        fmt_bytes[6'(int'(len_view) + j)] = ASCII_ZERO |
          {4'h0, 4'(cnt_digits >> (4 * (int'(cnt_ndigits) - 1 - j)))};
    fmt_bytes[6'(int'(len_view) + int'(cnt_ndigits))] = MD5_PAD_BYTE;
    bit_len = 64'(int'(len_view) + int'(cnt_ndigits)) << 3;
    for (int k = 0; k < 8; k++) fmt_bytes[LENGTH_FIELD_OFFSET + k] = bit_len[8*k +: 8];
    for (int p = 0; p < 64; p++) fmt_block[8*p +: 8] = fmt_bytes[p];
  end

  // The counter runs one nonce ahead of the block register, holding the next block to load.
  bcd_counter #(
    .COUNTER_DIGITS(COUNTER_DIGITS),
    .NONCE_WIDTH   (NONCE_WIDTH)
  ) u_counter (
    .clk    (clk),
    .clear  (reset),
    .incr   (load_block && !cnt_at_max),
    .digits (cnt_digits),
    .ndigits(cnt_ndigits),
    .binary (cnt_binary),
    .at_max (cnt_at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      block_valid_q  <= 1'b0;
      block_nonce_q  <= NONCE_WIDTH'(1);
      block_at_max_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      block_valid_q <= (state_d == ST_RUN);
      if (handshake && block_at_max_q) overflow_q <= 1'b1;
      if (load_block) begin
        block_nonce_q  <= cnt_binary;
        block_at_max_q <= cnt_at_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_block) block_q <= fmt_block;
  end

  assign block_valid = block_valid_q;
  assign block_data  = BLOCK_WIDTH'(block_q);
  assign block_nonce = block_nonce_q;
  assign key_error   = key_error_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_md5_block_builder.sv
// tb/tb_md5_block_builder.sv - scoreboard bench for md5_block_builder
module tb_md5_block_builder;
  import md5_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_key_valid, a_key_ready, a_key_last, a_key_error;
  logic        a_block_valid, a_block_ready, a_stop, a_overflow, a_halted;
  byte_t       a_key_data;
  block_t      a_block_data;
  logic [31:0] a_block_nonce;
  logic        b_key_valid, b_key_ready, b_key_last, b_key_error;
  logic        b_block_valid, b_block_ready, b_stop, b_overflow, b_halted;
  byte_t       b_key_data;
  block_t      b_block_data;
  logic [31:0] b_block_nonce;

  md5_block_builder dut_a (
    .clk(clk), .reset(reset),
    .key_valid(a_key_valid), .key_ready(a_key_ready), .key_data(a_key_data),
    .key_last(a_key_last), .key_error(a_key_error),
    .block_valid(a_block_valid), .block_ready(a_block_ready),
    .block_data(a_block_data), .block_nonce(a_block_nonce),
    .stop(a_stop), .overflow(a_overflow), .halted(a_halted)
  );

  md5_block_builder #(.COUNTER_DIGITS(2)) dut_b (
    .clk(clk), .reset(reset),
    .key_valid(b_key_valid), .key_ready(b_key_ready), .key_data(b_key_data),
    .key_last(b_key_last), .key_error(b_key_error),
    .block_valid(b_block_valid), .block_ready(b_block_ready),
    .block_data(b_block_data), .block_nonce(b_block_nonce),
    .stop(b_stop), .overflow(b_overflow), .halted(b_halted)
  );

  typedef struct {
    block_t      data;
    int unsigned nonce;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic block_t model(input string key, input int unsigned nonce);
    string       s;
    byte_t       b [64];
    logic [63:0] bl;
    block_t      r;
    s = {key, $sformatf("%0d", nonce)};
    for (int p = 0; p < 64; p++) b[p] = 8'h00;
    for (int i = 0; i < s.len(); i++) b[i] = s[i];
    b[s.len()] = 8'h80;
    bl = 64'(s.len()) * 64'd8;
    for (int k = 0; k < 8; k++) b[56 + k] = bl[8*k +: 8];
    for (int p = 0; p < 64; p++) r[8*p +: 8] = b[p];
    return r;
  endfunction

  task automatic push(input int which, input string key, input int unsigned nonce);
    exp_t e;
    e.data  = model(key, nonce);
    e.nonce = nonce;
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
  endtask

  task automatic score(input int which, input block_t d, input logic [31:0] n);
    exp_t e;
    int   sz;
    sz = (which == 0) ? q_a.size() : q_b.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_block: got nonce %0d, none expected", which, n);
    end else begin
      if (which == 0) e = q_a.pop_front();
      else            e = q_b.pop_front();
      check($sformatf("dut%0d_block_data_n%0d", which, e.nonce), d, e.data);
      check($sformatf("dut%0d_block_nonce", which), 512'(n), 512'(e.nonce));
    end
  endtask

  logic        a_prev_stall = 1'b0;
  block_t      a_prev_data;
  logic [31:0] a_prev_nonce;

  always @(negedge clk) begin : mon_a
    if (!reset) begin
      if (a_prev_stall && a_block_valid) begin
        check("a_stall_data", a_block_data, a_prev_data);
        check("a_stall_nonce", 512'(a_block_nonce), 512'(a_prev_nonce));
      end
      if (a_block_valid && a_block_ready) score(0, a_block_data, a_block_nonce);
    end
    a_prev_stall = !reset && a_block_valid && !a_block_ready;
    a_prev_data  = a_block_data;
    a_prev_nonce = a_block_nonce;
  end

  always @(negedge clk) begin : mon_b
    if (!reset && b_block_valid && b_block_ready) score(1, b_block_data, b_block_nonce);
  end

  task automatic send_key(input int which, input string k);
    for (int i = 0; i < k.len(); i++) begin
      @(posedge clk); #1;
      if (which == 0) begin
        a_key_valid = 1'b1; a_key_data = k[i]; a_key_last = (i == k.len() - 1);
      end else begin
        b_key_valid = 1'b1; b_key_data = k[i]; b_key_last = (i == k.len() - 1);
      end
    end
    @(posedge clk); #1;
    a_key_valid = 1'b0; a_key_last = 1'b0;
    b_key_valid = 1'b0; b_key_last = 1'b0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready high and stop on nonce 5
  task automatic drain(input int which, input int mode, input int budget);
    int cyc = 0;
    int sz;
    while (cyc < budget) begin
      @(posedge clk); #1;
      sz = (which == 0) ? q_a.size() : q_b.size();
      if (sz == 0) break;
      if (which == 0) begin
        a_block_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        a_stop        = (mode == 2) && (a_block_nonce == 32'd5);
      end else begin
        b_block_ready = 1'b1;
      end
      cyc++;
    end
    a_block_ready = 1'b0; a_stop = 1'b0; b_block_ready = 1'b0;
    sz = (which == 0) ? q_a.size() : q_b.size();
    check($sformatf("dut%0d_drain_left", which), 512'(sz), 512'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_key_valid = 1'b0; a_key_data = 8'h00; a_key_last = 1'b0; a_block_ready = 1'b0; a_stop = 1'b0;
    b_key_valid = 1'b0; b_key_data = 8'h00; b_key_last = 1'b0; b_block_ready = 1'b0; b_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_key_ready", 512'(a_key_ready), 512'(1));
    check("rst_block_valid", 512'(a_block_valid), 512'(0));
    check("rst_block_nonce", 512'(a_block_nonce), 512'(1));
    check("rst_key_error", 512'(a_key_error), 512'(0));
    check("rst_overflow", 512'(a_overflow), 512'(0));
    check("rst_halted", 512'(a_halted), 512'(0));

    send_key(0, "abcdef");
    @(negedge clk);
    check("first_valid", 512'(a_block_valid), 512'(1));
    check("first_chars", 512'(a_block_data[55:0]), 512'(56'h31666564636261));
    check("first_pad", 512'(a_block_data[63:56]), 512'(8'h80));
    check("first_len", 512'(a_block_data[511:448]), 512'(64'h38));
    check("first_nonce", 512'(a_block_nonce), 512'(1));
    check("run_key_ready", 512'(a_key_ready), 512'(0));
    check("run_key_error", 512'(a_key_error), 512'(0));

    for (int n = 1; n <= 20; n++) push(0, "abcdef", n);
    drain(0, 0, 200);
    @(negedge clk);
    check("n21_chars", 512'(a_block_data[63:0]), 512'(64'h3132666564636261));
    check("n21_pad", 512'(a_block_data[71:64]), 512'(8'h80));
    check("n21_len", 512'(a_block_data[511:448]), 512'(64'h40));

    for (int n = 21; n <= 1100; n++) push(0, "abcdef", n);
    drain(0, 1, 20000);
    @(negedge clk);
    check("n1101_chars", 512'(a_block_data[79:0]), 512'(80'h31303131666564636261));
    check("n1101_pad", 512'(a_block_data[87:80]), 512'(8'h80));
    check("n1101_len", 512'(a_block_data[511:448]), 512'(64'h50));
    check("n1101_nonce", 512'(a_block_nonce), 512'(1101));

    @(posedge clk); #1;
    reset = 1'b1; a_block_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_valid", 512'(a_block_valid), 512'(0));
    check("midrun_rst_key_ready", 512'(a_key_ready), 512'(1));
    @(posedge clk); #1;
    reset = 1'b0; a_block_ready = 1'b0;

    for (int n = 1; n <= 5; n++) push(0, "xy", n);
    send_key(0, "xy");
    @(negedge clk);
    check("xy_chars", 512'(a_block_data[23:0]), 512'(24'h317978));
    check("xy_pad", 512'(a_block_data[31:24]), 512'(8'h80));
    check("xy_len", 512'(a_block_data[511:448]), 512'(64'h18));
    check("xy_nonce", 512'(a_block_nonce), 512'(1));
    drain(0, 2, 100);
    @(negedge clk);
    check("stop_valid", 512'(a_block_valid), 512'(0));
    check("stop_halted", 512'(a_halted), 512'(1));
    check("stop_nonce_incr", 512'(a_block_nonce), 512'(6));
    check("stop_key_ready", 512'(a_key_ready), 512'(0));
    check("stop_overflow", 512'(a_overflow), 512'(0));
    @(posedge clk); #1;
    a_key_valid = 1'b1; a_key_data = 8'h7a; a_key_last = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_key_valid = 1'b0; a_key_last = 1'b0;
    @(negedge clk);
    check("halt_ignore_key_halted", 512'(a_halted), 512'(1));
    check("halt_ignore_key_valid", 512'(a_block_valid), 512'(0));
    check("halt_ignore_key_error", 512'(a_key_error), 512'(0));

    for (int n = 1; n <= 99; n++) push(1, "ABCDEFGHIJKLMNOP", n);
    send_key(1, "ABCDEFGHIJKLMNOPQ");
    @(negedge clk);
    check("b_key_error", 512'(b_key_error), 512'(1));
    check("b_first_key", 512'(b_block_data[127:0]), 512'(128'h504F4E4D4C4B4A494847464544434241));
    check("b_first_digit", 512'(b_block_data[143:128]), 512'(16'h8031));
    check("b_first_len", 512'(b_block_data[511:448]), 512'(64'h88));
    drain(1, 0, 500);
    @(negedge clk);
    check("b_overflow", 512'(b_overflow), 512'(1));
    check("b_halted", 512'(b_halted), 512'(1));
    check("b_valid_after_max", 512'(b_block_valid), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
